// File: rtl/mm_final_sub_if.sv
`default_nettype none
// ============================================================================
// Module   : mm_final_sub_if
// Brief    : Request/result bundle of the Montgomery final-subtraction stage.
// Revision : 1.0
// ============================================================================
interface mm_final_sub_if #(
    parameter int REG_SIZE = 384
);
    logic                start_i;
    logic [REG_SIZE-1:0] x_i;
    logic                x_msb_i;
    logic [REG_SIZE-1:0] r_o;
    logic                valid_o;
    logic                ready_o;

    modport master (
        output start_i, x_i, x_msb_i,
        input  r_o, valid_o, ready_o
    );

    modport slave (
        input  start_i, x_i, x_msb_i,
        output r_o, valid_o, ready_o
    );
endinterface
`default_nettype wire

// File: rtl/mm_final_sub.sv
`default_nettype none
// ============================================================================
// Module   : mm_final_sub
// Brief    : Word-serial conditional subtraction x - p reducing [0, 2p) to [0, p).
// Revision : 1.0
// ============================================================================
module mm_final_sub #(
    parameter int                  REG_SIZE = 384,
    parameter int                  RADIX    = 32,
    parameter logic [REG_SIZE-1:0] PRIME    = 384'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffffe_ffffffff_00000000_00000000_ffffffff
) (
    input  logic          clk,
    input  logic          reset_n,
    mm_final_sub_if.slave bus
);
    localparam int NW = REG_SIZE / RADIX;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [CW-1:0]                c_LAST    = CW'(NW - 1);
    localparam logic [NW-1:0][RADIX-1:0]     c_PRIME_W = PRIME;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_SEL  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [NW-1:0][RADIX-1:0] r_x;
    logic [NW-1:0][RADIX-1:0] r_d;
    logic                    r_msb;
    logic                    r_borrow;
    logic [CW-1:0]           r_cnt;
    logic [REG_SIZE-1:0]     r_r;
    logic                    r_valid;

    logic                    w_load;
    logic                    w_step;
    logic                    w_sel;
    logic                    w_ready;
    logic                    w_last;
    logic [RADIX:0]          w_diff;

    // One RADIX-bit slice of x - p per cycle; the extra top bit is the borrow out.
    assign w_diff = {1'b0, r_x[r_cnt]} - {1'b0, c_PRIME_W[r_cnt]} - {{RADIX{1'b0}}, r_borrow};
    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_sel       = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SUB;
                end
            end
            S_SUB: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                w_sel       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x      <= '0;
            r_d      <= '0;
            r_msb    <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_r      <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_sel;
            if (w_load) begin
                r_x      <= bus.x_i;
                r_msb    <= bus.x_msb_i;
                r_borrow <= 1'b0;
                r_cnt    <= '0;
                r_d      <= '0;
            end
            if (w_step) begin
                r_d[r_cnt] <= w_diff[RADIX-1:0];
                r_borrow   <= w_diff[RADIX];
                r_cnt      <= w_last ? '0 : r_cnt + CW'(1);
            end
            // Overflow bit set means x >= 2^REG_SIZE > p; the dropped top bit of d cancels it.
            if (w_sel) begin
                r_r <= (r_msb | ~r_borrow) ? r_d : r_x;
            end
        end
    end

    assign bus.r_o     = r_r;
    assign bus.valid_o = r_valid;
    assign bus.ready_o = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_mm_final_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_final_sub
// Brief    : Self-checking bench for mm_final_sub: vector table, corner sequences, random ops.
// Revision : 1.0
// ============================================================================
module tb_mm_final_sub;
    localparam logic [383:0] c_P = 384'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffffe_ffffffff_00000000_00000000_ffffffff;
    localparam int c_LAT = 13;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    mm_final_sub_if #(.REG_SIZE(384)) bus ();

    mm_final_sub dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         msb;
        logic [383:0] x;
        logic [383:0] exp;
    } vec_t;

    vec_t vecs [7];

    // Reference: the value {msb,x} reduced once modulo p with plain wide arithmetic.
    function automatic logic [383:0] ref_reduce(input logic msb, input logic [383:0] x);
        logic [384:0] v;
        v = {msb, x};
        if (v >= {1'b0, c_P}) v = v - {1'b0, c_P};
        return v[383:0];
    endfunction

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic do_start(input logic msb, input logic [383:0] x);
        bus.start_i = 1'b1;
        bus.x_i     = x;
        bus.x_msb_i = msb;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.x_i     = ~x;
        bus.x_msb_i = ~msb;
    endtask

    // Waits for valid_o, checking latency, busy time and the result; optionally pokes start_i mid-op.
    task automatic wait_result(input logic [383:0] exp, input string name, input bit pulses);
        int lat;
        int busy;
        lat  = 0;
        busy = bus.ready_o ? 0 : 1;
        while (!bus.valid_o && lat < 40) begin
            if (pulses && (lat == 2 || lat == 7)) begin
                bus.start_i = 1'b1;
                bus.x_i     = {12{$urandom}};
                bus.x_msb_i = 1'b0;
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (!bus.valid_o && !bus.ready_o) busy++;
        end
        bus.start_i = 1'b0;
        check({name, " latency"}, 384'(lat), 384'(c_LAT));
        check({name, " busy"}, 384'(busy), 384'(c_LAT));
        check({name, " r_o"}, bus.r_o, exp);
    endtask

    task automatic check_after(input logic [383:0] exp, input string name);
        @(negedge clk);
        check({name, " valid drop"}, 384'(bus.valid_o), 384'(0));
        check({name, " r_o hold"}, bus.r_o, exp);
    endtask

    initial begin
        logic [384:0] t2p;
        logic [383:0] xa;
        logic [383:0] xb;
        logic         ma;
        int           seen;

        n_cmp       = 0;
        n_bad       = 0;
        reset_n     = 1'b0;
        bus.start_i = 1'b0;
        bus.x_i     = '0;
        bus.x_msb_i = 1'b0;

        t2p = 2 * {1'b0, c_P} - 385'd1;
        vecs[0] = '{"zero",      1'b0, 384'd0,                        384'd0};
        vecs[1] = '{"x_eq_p",    1'b0, c_P,                           384'd0};
        vecs[2] = '{"p_minus_1", 1'b0, c_P - 384'd1,                  c_P - 384'd1};
        vecs[3] = '{"p_plus_5",  1'b0, c_P + 384'd5,                  384'd5};
        vecs[4] = '{"p_plus_w",  1'b0, c_P + (384'd1 << 32),          384'd1 << 32};
        vecs[5] = '{"2p_minus1", t2p[384], t2p[383:0],                c_P - 384'd1};
        vecs[6] = '{"two_pow_n", 1'b1, 384'd0, 384'h1_00000000_ffffffff_ffffffff_00000001};

        repeat (2) @(negedge clk);
        check("reset r_o", bus.r_o, 384'd0);
        check("reset valid", 384'(bus.valid_o), 384'd0);
        check("reset ready", 384'(bus.ready_o), 384'd1);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_start(vecs[i].msb, vecs[i].x);
            wait_result(vecs[i].exp, vecs[i].name, 1'b0);
            check_after(vecs[i].exp, vecs[i].name);
        end

        // Starts while busy must be ignored.
        xa = c_P + 384'd123;
        do_start(1'b0, xa);
        wait_result(384'd123, "ignore_start", 1'b1);
        check_after(384'd123, "ignore_start");
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.valid_o) seen++;
        end
        check("ignore_start no extra valid", 384'(seen), 384'd0);

        // Back-to-back: second start in the valid cycle.
        xa = c_P + 384'd77;
        xb = c_P - 384'd9;
        do_start(1'b0, xa);
        wait_result(384'd77, "b2b first", 1'b0);
        do_start(1'b0, xb);
        check("b2b r_o held", bus.r_o, 384'd77);
        check("b2b ready low", 384'(bus.ready_o), 384'd0);
        wait_result(c_P - 384'd9, "b2b second", 1'b0);
        check_after(c_P - 384'd9, "b2b second");

        // Reset in the middle of an operation.
        do_start(1'b0, c_P + 384'd42);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset r_o", bus.r_o, 384'd0);
        check("midreset valid", 384'(bus.valid_o), 384'd0);
        check("midreset ready", 384'(bus.ready_o), 384'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.valid_o) seen++;
        end
        check("midreset no valid", 384'(seen), 384'd0);
        do_start(1'b0, c_P + 384'd5);
        wait_result(384'd5, "after_reset", 1'b0);
        check_after(384'd5, "after_reset");

        // Random operands in [0, 2p).
        for (int k = 0; k < 40; k++) begin
            for (int w = 0; w < 12; w++) xa[w*32 +: 32] = $urandom;
            ma = ($urandom_range(0, 3) == 0);
            if (k % 5 == 1) xa = c_P + 384'($urandom);
            if (k % 5 == 2) xa = c_P - 384'($urandom_range(0, 1000));
            if (ma && ({1'b1, xa} >= 2 * {1'b0, c_P})) ma = 1'b0;
            do_start(ma, xa);
            wait_result(ref_reduce(ma, xa), $sformatf("rand%0d", k), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mm_final_sub.md
Name: mm_final_sub

Overview:
- Final conditional-subtraction stage directly downstream of the Montgomery multiplier in the ECC arithmetic datapath.
- Takes the multiplier's 384-bit product plus its overflow bit, which lies in [0, 2p).
- Computes x - p word-serially on a RADIX-bit borrow chain, one word per cycle. This reuses the multiplier's word width and avoids a 384-bit carry path.
- Returns the fully reduced result in [0, p) with a one-cycle valid pulse.

Parameters:
- REG_SIZE, 384, operand/result width in bits.
- RADIX, 32, word width of the serial subtractor; REG_SIZE must be a multiple of RADIX.
- PRIME, 384'hffff...fffeffffffff0000000000000000ffffffff (P-384 prime), modulus p subtracted.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start_i  input  1  single-cycle request; accepted only when ready_o=1.
- x_i  input  REG_SIZE  low REG_SIZE bits of the value to reduce; sampled on the accepting edge.
- x_msb_i  input  1  bit REG_SIZE (overflow) of the value to reduce; sampled with x_i.
- r_o  output  REG_SIZE  reduced result; held until the next result or reset.
- valid_o  output  1  one-cycle pulse: r_o updated this cycle.
- ready_o  output  1  block idle, can accept start_i.

Behaviour:
- Clock clk; reset reset_n, asynchronous, active-low.
- Reset values: state=IDLE, r_o=0, valid_o=0, ready_o=1; internal x_reg, d_reg, borrow, word counter all 0.
- NW = REG_SIZE/RADIX (12 at defaults). Word counter is ceil(log2(NW)) bits.
- FSM states:
  - IDLE: ready_o=1 (combinational decode of state). start_i=1 at edge E0 loads x_reg<=x_i, msb_reg<=x_msb_i, borrow<=0, cnt<=0, d_reg<=0; -> SUB.
  - SUB: each edge computes word w=cnt, {b', dw} = x_reg[w] - PRIME[w] - borrow (RADIX+1-bit subtract, b' = borrow out); d_reg[w]<=dw, borrow<=b', cnt<=cnt+1. At edge with cnt=NW-1 -> SEL; cnt wraps to 0.
  - SEL: one edge: r_o <= (msb_reg | ~borrow) ? d_reg : x_reg; valid_o<=1; -> IDLE.
- valid_o is high exactly one cycle: the cycle after the SEL edge. It deasserts on the following edge unless a new result is produced.
- Latency: start at E0 -> SUB edges E1..E12 -> SEL edge E13; r_o/valid_o visible after E13 (13 cycles at defaults, NW+1 in general).
- ready_o low from after E0 until after E13. Throughput is one operation per NW+1 cycles; back-to-back start on the cycle valid_o is high is accepted.
- start_i while not IDLE: ignored; no effect on state, data or outputs.
- Selection rule:
  - msb=1 means x ≥ 2^REG_SIZE > p, so subtract; the REG_SIZE-bit d_reg is the correct modular result because the discarded bit cancels.
  - msb=0 with final borrow=1 means x < p, so keep x.
  - Otherwise output x - p.
- Only one subtraction is performed. Inputs ≥ 2p are outside the contract; the block returns x - p truncated to REG_SIZE bits.
- Reset asserted mid-operation: immediate return to reset values; the in-flight operation is lost and no valid_o is produced.
- r_o holds its value across IDLE and during subsequent operations until the next SEL edge.

Test Plan:
- x_i=0, x_msb_i=0, single start -> ready_o low 13 cycles; valid_o pulse after E13; r_o=0.
- x_i=PRIME, msb=0 -> r_o=0. x_i=PRIME-1 -> r_o=PRIME-1. x_i=PRIME+5 -> r_o=5. Word-boundary borrow: x_i=PRIME+2^32 -> r_o=2^32.
- x_msb_i=1, x_i=(2*PRIME-1) mod 2^384 -> r_o=PRIME-1. x_msb_i=1, x_i=(PRIME+2^384) mod 2^384 + 7, i.e. value p+2^384... restricted to <2p: use x=2^384, x_i=0 -> r_o=2^384-PRIME.
- start_i pulsed at cycles 3 and 8 during a busy operation with different x_i -> ignored; single valid_o with the first operand's result.
- Back-to-back: second start_i in the valid_o cycle -> accepted; second valid_o exactly 13 cycles later; each r_o correct.
- reset_n low at cycle 6 of an operation -> r_o=0, valid_o=0, ready_o=1 immediately; no valid_o; a fresh start afterwards completes normally with latency 13.
